// File: rtl/spi_adc_pkg.sv
// Shared types, defaults and command encoding for the ADC scan sequencer.
package spi_adc_pkg;

    localparam int unsigned DEF_DATA_W  = 24;
    localparam int unsigned DEF_CMD_W   = 8;
    localparam int unsigned DEF_NUM_CH  = 4;
    localparam int unsigned DEF_CLK_DIV = 4;
    localparam int unsigned CMD_MAX_W   = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PICK,
        ST_CS_SETUP,
        ST_SHIFT,
        ST_CS_HOLD,
        ST_OUTPUT,
        ST_DONE
    } seq_state_e;

    // Command word is the channel index, zero-extended; callers truncate to CMD_W.
    function automatic logic [CMD_MAX_W-1:0] make_cmd(input logic [CMD_MAX_W-1:0] ch);
        return ch;
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK generator: CLK_DIV cycles low then CLK_DIV cycles high while enabled,
// with strobes marking the cycle whose closing edge raises or drops SCLK.
module spi_sclk_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clock_i,
    input  logic reset_ni,
    input  logic en_i,
    output logic SCLK_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sclk_q, sclk_d;
    logic             last_c;

    assign last_c = (cnt_q == CNT_W'(CLK_DIV - 1));

    // Disabled means parked at the start of a low phase.
    always_comb begin
        cnt_d  = cnt_q;
        sclk_d = sclk_q;
        if (!en_i) begin
            cnt_d  = '0;
            sclk_d = 1'b0;
        end else if (last_c) begin
            cnt_d  = '0;
            sclk_d = ~sclk_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

    assign SCLK_o = sclk_q;
    assign rise_o = en_i & ~sclk_q & last_c;
    assign fall_o = en_i & sclk_q & last_c;

endmodule

// File: rtl/spi_adc_sequencer.sv
// Scan controller: walks the latched channel mask, runs one SPI frame per
// channel and hands each captured sample out on a valid/ready stream.
module spi_adc_sequencer
    import spi_adc_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned CMD_W   = DEF_CMD_W,
    parameter int unsigned NUM_CH  = DEF_NUM_CH,
    parameter int unsigned CLK_DIV = DEF_CLK_DIV,
    parameter int unsigned CH_W    = $clog2(NUM_CH)
) (
    input  logic              clock_i,
    input  logic              reset_ni,
    input  logic              start_i,
    input  logic [NUM_CH-1:0] ch_mask_i,
    output logic              busy_o,
    output logic              scan_done_o,
    output logic              SCLK_o,
    output logic              CS_no,
    output logic              MOSI_o,
    input  logic              MISO_i,
    output logic              sample_valid_o,
    input  logic              sample_ready_i,
    output logic [DATA_W-1:0] sample_data_o,
    output logic [CH_W-1:0]   sample_ch_o
);

    localparam int unsigned TOTAL_W = CMD_W + DATA_W;
    localparam int unsigned BIT_W   = $clog2(TOTAL_W + 1);
    localparam int unsigned DIV_W   = $clog2(CLK_DIV + 1);

    seq_state_e        state_q, state_d;
    logic [NUM_CH-1:0] pending_q, pending_d;
    logic [CH_W-1:0]   cur_ch_q, cur_ch_d, pick_ch;
    logic [CMD_W-1:0]  cmd_q, cmd_d;
    logic [DATA_W-1:0] cap_q, cap_d, data_q, data_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic              cs_n_q, cs_n_d, mosi_q, mosi_d, valid_q, valid_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic              div_last, sclk_en, sclk_rise, sclk_fall;

    spi_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk (
        .clock_i  (clock_i),
        .reset_ni (reset_ni),
        .en_i     (sclk_en),
        .SCLK_o   (SCLK_o),
        .rise_o   (sclk_rise),
        .fall_o   (sclk_fall)
    );

    assign sclk_en  = (state_q == ST_SHIFT);
    assign div_last = (div_q == DIV_W'(CLK_DIV - 1));

    // Lowest pending channel: the last assignment in a descending walk wins.
    always_comb begin
        pick_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pending_q[i]) pick_ch = CH_W'(i);
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        cur_ch_d  = cur_ch_q;
        cmd_d     = cmd_q;
        cap_d     = cap_q;
        bit_d     = bit_q;
        div_d     = div_q;
        mosi_d    = mosi_q;
        data_d    = data_q;
        ch_d      = ch_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    pending_d = ch_mask_i;
                    state_d   = ST_PICK;
                end
            end
            ST_PICK: begin
                if (pending_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    cur_ch_d  = pick_ch;
                    pending_d = pending_q & (pending_q - NUM_CH'(1));
                    cmd_d     = CMD_W'(make_cmd(CMD_MAX_W'(pick_ch)));
                    mosi_d    = cmd_d[CMD_W-1];
                    cap_d     = '0;
                    bit_d     = '0;
                    div_d     = '0;
                    state_d   = ST_CS_SETUP;
                end
            end
            ST_CS_SETUP: begin
                if (div_last) begin
                    div_d   = '0;
                    state_d = ST_SHIFT;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_SHIFT: begin
                if (sclk_rise) bit_d = bit_q + BIT_W'(1);
                // bit_q holds the 1-based index of the period whose high phase is ending.
                if (sclk_fall) begin
                    cmd_d  = cmd_q << 1;
                    mosi_d = cmd_d[CMD_W-1];
                    if (bit_q > BIT_W'(CMD_W)) cap_d = DATA_W'({cap_q, MISO_i});
                    if (bit_q == BIT_W'(TOTAL_W)) state_d = ST_CS_HOLD;
                end
            end
            ST_CS_HOLD: begin
                if (div_last) begin
                    div_d   = '0;
                    data_d  = cap_q;
                    ch_d    = cur_ch_q;
                    state_d = ST_OUTPUT;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_OUTPUT: begin
                if (sample_ready_i) state_d = ST_PICK;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        cs_n_d  = !(state_d inside {ST_CS_SETUP, ST_SHIFT, ST_CS_HOLD});
        valid_d = (state_d == ST_OUTPUT);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            cur_ch_q  <= '0;
            cmd_q     <= '0;
            cap_q     <= '0;
            bit_q     <= '0;
            div_q     <= '0;
            cs_n_q    <= 1'b1;
            mosi_q    <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            ch_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            cur_ch_q  <= cur_ch_d;
            cmd_q     <= cmd_d;
            cap_q     <= cap_d;
            bit_q     <= bit_d;
            div_q     <= div_d;
            cs_n_q    <= cs_n_d;
            mosi_q    <= mosi_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            ch_q      <= ch_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign CS_no          = cs_n_q;
    assign MOSI_o         = mosi_q;
    assign sample_valid_o = valid_q;
    assign sample_data_o  = data_q;
    assign sample_ch_o    = ch_q;
    assign busy_o         = busy_q;
    assign scan_done_o    = done_q;

endmodule

// File: tb/tb_spi_adc_sequencer.sv
// Bench for spi_adc_sequencer: ADC slave model, frame/handshake monitor and
// a sample scoreboard filled when each scan is started.
module tb_spi_adc_sequencer;

    localparam int unsigned DATA_W    = 24;
    localparam int unsigned CMD_W     = 8;
    localparam int unsigned NUM_CH    = 4;
    localparam int unsigned CLK_DIV   = 2;
    localparam int unsigned CH_W      = 2;
    localparam int unsigned FRAME_CYC = CLK_DIV * (2 * (CMD_W + DATA_W) + 2);

    typedef struct packed {
        logic [CH_W-1:0]   ch;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset_ni = 1'b0;
    logic              start_i = 1'b0;
    logic [NUM_CH-1:0] ch_mask_i = '0;
    logic              MISO_i = 1'b0;
    logic              sample_ready_i = 1'b1;
    logic              busy_o, scan_done_o, SCLK_o, CS_no, MOSI_o, sample_valid_o;
    logic [DATA_W-1:0] sample_data_o;
    logic [CH_W-1:0]   sample_ch_o;

    spi_adc_sequencer #(
        .DATA_W  (DATA_W),
        .CMD_W   (CMD_W),
        .NUM_CH  (NUM_CH),
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clock_i        (clk),
        .reset_ni       (reset_ni),
        .start_i        (start_i),
        .ch_mask_i      (ch_mask_i),
        .busy_o         (busy_o),
        .scan_done_o    (scan_done_o),
        .SCLK_o         (SCLK_o),
        .CS_no          (CS_no),
        .MOSI_o         (MOSI_o),
        .MISO_i         (MISO_i),
        .sample_valid_o (sample_valid_o),
        .sample_ready_i (sample_ready_i),
        .sample_data_o  (sample_data_o),
        .sample_ch_o    (sample_ch_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    exp_t              sb[$];
    logic [CMD_W-1:0]  exp_cmd[$];
    logic [DATA_W-1:0] adc_val[NUM_CH];

    // ADC slave: decodes the command, drives MISO after each SCLK rise.
    int unsigned       per = 0;
    int unsigned       bit_idx = 0;
    logic [CMD_W-1:0]  cmd_rx = '0;
    logic [CMD_W-1:0]  last_cmd = '0;
    logic [DATA_W-1:0] cur_word = '0;
    logic              m_sclk_prev = 1'b0;

    always @(negedge clk) begin
        if (CS_no) begin
            per = 0;
        end else if (SCLK_o && !m_sclk_prev) begin
            if (per < CMD_W) begin
                cmd_rx = {cmd_rx[CMD_W-2:0], MOSI_o};
                MISO_i = 1'($urandom);
                if (per == CMD_W - 1) begin
                    last_cmd = cmd_rx;
                    cur_word = adc_val[cmd_rx[CH_W-1:0]];
                end
            end else begin
                bit_idx = DATA_W - 1 - (per - CMD_W);
                MISO_i  = cur_word[bit_idx];
            end
            per++;
        end
        m_sclk_prev = SCLK_o;
    end

    // Monitor
    logic              cs_prev = 1'b1, sclk_prev = 1'b0, valid_prev = 1'b0, done_prev = 1'b0;
    logic              frame_active = 1'b0;
    int                cs_fall_cyc = 0, rises = 0, cs_falls = 0, samples_seen = 0;
    int                done_cnt = 0, sclk_bad = 0, last_event = 0;
    logic [DATA_W-1:0] hold_data = '0;
    logic [CH_W-1:0]   hold_ch = '0;
    exp_t              e;

    always @(negedge clk) begin
        if (!reset_ni) begin
            frame_active = 1'b0;
            cs_prev      = 1'b1;
            sclk_prev    = 1'b0;
            valid_prev   = 1'b0;
            done_prev    = 1'b0;
        end else begin
            if (cs_prev && !CS_no) begin
                check("cs_fall_latency", 64'(cyc), 64'(last_event + 2));
                cs_fall_cyc  = cyc;
                rises        = 0;
                cs_falls++;
                frame_active = 1'b1;
            end
            if (!cs_prev && CS_no && frame_active) begin
                check("cs_low_len", 64'(cyc - cs_fall_cyc), 64'(FRAME_CYC));
                check("sclk_periods", 64'(rises), 64'(CMD_W + DATA_W));
                check("valid_with_cs_rise", 64'(sample_valid_o), 64'(1));
                if (exp_cmd.size() != 0) check("mosi_cmd", 64'(last_cmd), 64'(exp_cmd.pop_front()));
                frame_active = 1'b0;
            end
            if (SCLK_o && !sclk_prev) rises++;
            if (SCLK_o && CS_no) sclk_bad++;
            if (sample_valid_o) begin
                if (valid_prev) begin
                    check("hold_data", 64'(sample_data_o), 64'(hold_data));
                    check("hold_ch", 64'(sample_ch_o), 64'(hold_ch));
                end
                hold_data = sample_data_o;
                hold_ch   = sample_ch_o;
                if (sample_ready_i) begin
                    samples_seen++;
                    last_event = cyc;
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        check("sample_ch", 64'(sample_ch_o), 64'(e.ch));
                        check("sample_data", 64'(sample_data_o), 64'(e.data));
                    end
                end else begin
                    check("stall_cs_high", 64'(CS_no), 64'(1));
                    check("stall_sclk_low", 64'(SCLK_o), 64'(0));
                end
            end
            if (scan_done_o) begin
                done_cnt++;
                check("done_latency", 64'(cyc), 64'(last_event + 2));
                check("busy_at_done", 64'(busy_o), 64'(1));
            end
            if (done_prev) begin
                check("done_width", 64'(scan_done_o), 64'(0));
                check("busy_after_done", 64'(busy_o), 64'(0));
            end
            cs_prev    = CS_no;
            sclk_prev  = SCLK_o;
            valid_prev = sample_valid_o;
            done_prev  = scan_done_o;
        end
    end

    int s0 = 0, f0 = 0, d0 = 0, b0 = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_test();
        s0 = samples_seen;
        f0 = cs_falls;
        d0 = done_cnt;
        b0 = sclk_bad;
    endtask

    task automatic pulse_start(input logic [NUM_CH-1:0] mask, input bit accept);
        ch_mask_i = mask;
        start_i   = 1'b1;
        if (accept) begin
            last_event = cyc;
            for (int i = 0; i < NUM_CH; i++) begin
                if (mask[i]) begin
                    sb.push_back({CH_W'(i), adc_val[i]});
                    exp_cmd.push_back(CMD_W'(i));
                end
            end
        end
        tick();
        start_i   = 1'b0;
        ch_mask_i = '0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        int dc = done_cnt;
        while (done_cnt == dc && n < 20000) begin
            tick();
            n++;
        end
        check({tag, "_done_seen"}, 64'(done_cnt != dc), 64'(1));
    endtask

    task automatic end_test(input string tag, input int exp_s, input int exp_f);
        repeat (3) tick();
        check({tag, "_samples"}, 64'(samples_seen - s0), 64'(exp_s));
        check({tag, "_frames"}, 64'(cs_falls - f0), 64'(exp_f));
        check({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'(1));
        check({tag, "_sb_left"}, 64'(sb.size() + exp_cmd.size()), 64'(0));
        check({tag, "_sclk_idle"}, 64'(sclk_bad - b0), 64'(0));
        check({tag, "_busy_idle"}, 64'(busy_o), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < NUM_CH; i++) adc_val[i] = '0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_cs_n", 64'(CS_no), 64'(1));
        check("rst_sclk", 64'(SCLK_o), 64'(0));
        check("rst_mosi", 64'(MOSI_o), 64'(0));
        check("rst_valid", 64'(sample_valid_o), 64'(0));
        check("rst_data", 64'(sample_data_o), 64'(0));
        check("rst_ch", 64'(sample_ch_o), 64'(0));
        check("rst_busy", 64'(busy_o), 64'(0));
        check("rst_done", 64'(scan_done_o), 64'(0));
        tick();
        reset_ni = 1'b1;
        repeat (3) tick();

        // Two channels, ready tied high
        adc_val[0] = 24'hAABBCC;
        adc_val[2] = 24'h123456;
        begin_test();
        pulse_start(4'b0101, 1'b1);
        wait_done("basic");
        end_test("basic", 2, 2);

        // Empty mask
        begin_test();
        pulse_start(4'b0000, 1'b1);
        wait_done("empty");
        end_test("empty", 0, 0);

        // Backpressure on the first sample
        adc_val[0] = 24'h0F0F0F;
        adc_val[1] = 24'hC3A501;
        adc_val[2] = 24'h800000;
        adc_val[3] = 24'h5A5A5A;
        sample_ready_i = 1'b0;
        begin_test();
        pulse_start(4'b1111, 1'b1);
        n = 0;
        while (!sample_valid_o && n < 1000) begin
            tick();
            n++;
        end
        check("stall_valid_seen", 64'(sample_valid_o), 64'(1));
        repeat (50) tick();
        sample_ready_i = 1'b1;
        wait_done("stall");
        end_test("stall", 4, 4);

        // Start during a scan is ignored
        adc_val[0] = 24'h3C3C3C;
        adc_val[3] = 24'hDEADBE;
        begin_test();
        pulse_start(4'b1001, 1'b1);
        repeat (40) tick();
        pulse_start(4'b0110, 1'b0);
        wait_done("midstart");
        end_test("midstart", 2, 2);

        // Reset in the middle of a ch1 frame
        adc_val[1] = 24'h654321;
        begin_test();
        pulse_start(4'b0010, 1'b1);
        n = 0;
        while (cs_falls == f0 && n < 100) begin
            tick();
            n++;
        end
        n = 0;
        while (rises < 5 && n < 500) begin
            tick();
            n++;
        end
        check("rst_mid_in_shift", 64'(rises >= 5), 64'(1));
        reset_ni = 1'b0;
        sb.delete();
        exp_cmd.delete();
        tick();
        reset_ni = 1'b1;
        @(negedge clk);
        check("rst_mid_cs_n", 64'(CS_no), 64'(1));
        check("rst_mid_sclk", 64'(SCLK_o), 64'(0));
        check("rst_mid_busy", 64'(busy_o), 64'(0));
        check("rst_mid_valid", 64'(sample_valid_o), 64'(0));
        tick();
        repeat (200) tick();
        check("rst_mid_no_sample", 64'(samples_seen - s0), 64'(0));
        begin_test();
        pulse_start(4'b0010, 1'b1);
        wait_done("rst_fresh");
        end_test("rst_fresh", 1, 1);

        // Extreme data words with random MISO during the command phase
        adc_val[0] = 24'hFFFFFF;
        adc_val[1] = 24'h000001;
        begin_test();
        pulse_start(4'b0011, 1'b1);
        wait_done("extreme");
        end_test("extreme", 2, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
